// File: rtl/jk_bank_pkg.sv
// Shared encodings for the JK bank controller: command opcodes and FSM states.
package jk_bank_pkg;

  typedef enum logic [1:0] {
    OP_LOAD   = 2'b00,
    OP_SET    = 2'b01,
    OP_CLEAR  = 2'b10,
    OP_TOGGLE = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SETTLE = 2'd2
  } state_e;

endpackage

// File: rtl/jk_bank_ctrl_if.sv
// Command handshake between a requester (master) and the JK bank controller (slave).
interface jk_bank_ctrl_if #(
  parameter int WIDTH = 4
) ();

  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_data,
    output cmd_ready
  );

endinterface

// File: rtl/jk_bank_decode.sv
// Combinational translation of a command into per-bit J/K drive and the Q value
// the bank should hold once it has sampled that drive.
module jk_bank_decode
  import jk_bank_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] expected
);

  always_comb begin
    j        = '0;
    k        = '0;
    expected = q;
    unique case (op)
      OP_LOAD: begin
        j        = data;
        k        = ~data;
        expected = data;
      end
      OP_SET: begin
        j        = data;
        expected = q | data;
      end
      OP_CLEAR: begin
        k        = data;
        expected = q & ~data;
      end
      OP_TOGGLE: begin
        j        = data;
        k        = data;
        expected = q ^ data;
      end
    endcase
  end

endmodule

// File: rtl/jk_bank_ctrl.sv
// Sequencer that drives a JK bank for one cycle per command, then reports completion.
// Optional Q-readback checker enabled by defining JK_BANK_CHECK_EN.
module jk_bank_ctrl
  import jk_bank_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  jk_bank_ctrl_if.slave    cmd,
  output logic [WIDTH-1:0] jk_j,
  output logic [WIDTH-1:0] jk_k,
  input  logic [WIDTH-1:0] jk_q,
  output logic             done,
  output logic [CNT_W-1:0] cmd_count,
  output logic             err
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] j_q, k_q;
  logic             done_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] dec_j, dec_k, dec_exp;
  logic             accept;

  assign cmd.cmd_ready = (state_q == ST_IDLE) && !rst;
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;

  jk_bank_decode #(.WIDTH(WIDTH)) u_decode (
    .op       (op_e'(cmd.cmd_op)),
    .data     (cmd.cmd_data),
    .q        (jk_q),
    .j        (dec_j),
    .k        (dec_k),
    .expected (dec_exp)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (accept) state_d = ST_DRIVE;
      ST_DRIVE:  state_d = ST_SETTLE;
      ST_SETTLE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // J/K are non-zero only in the single cycle following an accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      j_q     <= '0;
      k_q     <= '0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      j_q     <= accept ? dec_j : '0;
      k_q     <= accept ? dec_k : '0;
      done_q  <= (state_d == ST_SETTLE);
      if (state_q == ST_SETTLE) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign jk_j      = j_q;
  assign jk_k      = k_q;
  assign done      = done_q;
  assign cmd_count = cnt_q;

`ifdef JK_BANK_CHECK_EN
  logic [WIDTH-1:0] exp_q;
  logic             err_q;

  // Expected Q is captured while the bank is idle and stable, compared once it has settled.
  always_ff @(posedge clk) begin
    if (rst) begin
      exp_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (accept) exp_q <= dec_exp;
      if ((state_q == ST_SETTLE) && (jk_q != exp_q)) err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  logic unused_dec_exp;
  assign unused_dec_exp = ^dec_exp;
  assign err            = 1'b0;
`endif

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Scoreboard bench for jk_bank_ctrl driving a 4-cell behavioural JK bank.
module tb_jk_bank_ctrl;
  import jk_bank_pkg::*;

  typedef struct {
    logic [3:0] q;
    logic [7:0] cnt;
    int         acc;
  } sb_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] jk_j, jk_k, jk_q_dut;
  logic       done, err;
  logic [7:0] cmd_count;
  logic [3:0] bank_q = 4'b0000;
  logic       force_zero = 1'b0;

  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  sb_t        sb_q[$];
  logic [3:0] model_q = 4'b0000;
  logic [7:0] model_cnt = 8'd0;

  jk_bank_ctrl_if #(.WIDTH(4)) bus ();

  jk_bank_ctrl #(.WIDTH(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd       (bus.slave),
    .jk_j      (jk_j),
    .jk_k      (jk_k),
    .jk_q      (jk_q_dut),
    .done      (done),
    .cmd_count (cmd_count),
    .err       (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      case ({jk_j[i], jk_k[i]})
        2'b01:   bank_q[i] <= 1'b0;
        2'b10:   bank_q[i] <= 1'b1;
        2'b11:   bank_q[i] <= ~bank_q[i];
        default: bank_q[i] <= bank_q[i];
      endcase
    end
  end

  assign jk_q_dut = force_zero ? 4'b0000 : bank_q;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] model_next(input logic [1:0] op, input logic [3:0] d, input logic [3:0] q);
    case (op)
      2'b00:   return d;
      2'b01:   return q | d;
      2'b10:   return q & ~d;
      default: return q ^ d;
    endcase
  endfunction

  function automatic logic [7:0] jk_of(input logic [1:0] op, input logic [3:0] d);
    case (op)
      2'b00:   return {d, ~d};
      2'b01:   return {d, 4'b0000};
      2'b10:   return {4'b0000, d};
      default: return {d, d};
    endcase
  endfunction

  task automatic expect_cmd(input logic [1:0] op, input logic [3:0] d, input logic corrupt);
    sb_t it;
    it.acc    = cyc;
    model_q   = model_next(op, d, model_q);
    it.q      = corrupt ? 4'b0000 : model_q;
    it.cnt    = model_cnt;
    model_cnt = model_cnt + 8'd1;
    sb_q.push_back(it);
  endtask

  task automatic wait_idle();
    int budget = 0;
    while (!bus.cmd_ready && budget < 10) begin
      @(negedge clk);
      budget++;
    end
    if (!bus.cmd_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout: cmd_ready still 0 after %0d cycles", budget);
    end
  endtask

  // Returns at the negedge of the DRIVE cycle.
  task automatic send(input logic [1:0] op, input logic [3:0] d, input logic corrupt);
    logic [7:0] jk;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = d;
    wait_idle();
    expect_cmd(op, d, corrupt);
    jk = jk_of(op, d);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = ~op;
    bus.cmd_data  = ~d;
    check("drive_j", jk_j, jk[7:4]);
    check("drive_k", jk_k, jk[3:0]);
    check("drive_ready", bus.cmd_ready, 1'b0);
  endtask

  task automatic finish_cmd();
    @(negedge clk);
    check("settle_j", jk_j, 4'b0000);
    check("settle_k", jk_k, 4'b0000);
    @(negedge clk);
    check("bank_q", jk_q_dut, model_q);
    check("count", cmd_count, model_cnt);
  endtask

  always @(negedge clk) begin
    sb_t it;
    if (!rst && done) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL done_unexpected: done=1 with no command outstanding at cycle %0d", cyc);
      end else begin
        it = sb_q.pop_front();
        check("done_q", jk_q_dut, it.q);
        check("done_count", cmd_count, it.cnt);
        check("done_latency", cyc - it.acc, 2);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_data  = 4'b0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", bus.cmd_ready, 1'b0);
    check("rst_j", jk_j, 4'b0000);
    check("rst_k", jk_k, 4'b0000);
    check("rst_done", done, 1'b0);
    check("rst_count", cmd_count, 8'd0);
    check("rst_err", err, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", bus.cmd_ready, 1'b1);

    send(OP_LOAD, 4'b1010, 1'b0);
    finish_cmd();
    send(OP_TOGGLE, 4'b0110, 1'b0);
    finish_cmd();
    send(OP_SET, 4'b0001, 1'b0);
    finish_cmd();
    send(OP_CLEAR, 4'b1000, 1'b0);
    finish_cmd();
    check("count_after_four", cmd_count, 8'd4);
    check("q_after_four", jk_q_dut, 4'b0101);

    // Valid held high: ready must only appear in IDLE, one accept every 3 cycles.
    wait_idle();
    bus.cmd_op    = OP_LOAD;
    bus.cmd_data  = 4'b1111;
    bus.cmd_valid = 1'b1;
    for (int k = 0; k < 9; k++) begin
      check("held_ready", bus.cmd_ready, (k % 3) == 0);
      if (bus.cmd_ready) expect_cmd(OP_LOAD, 4'b1111, 1'b0);
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    check("held_count", cmd_count, 8'd7);
    check("held_q", jk_q_dut, 4'b1111);

    // Reset in the DRIVE cycle of a TOGGLE.
    wait_idle();
    bus.cmd_op    = OP_TOGGLE;
    bus.cmd_data  = 4'b1111;
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check("rstdrv_j", jk_j, 4'b1111);
    check("rstdrv_k", jk_k, 4'b1111);
    rst = 1'b1;
    @(negedge clk);
    model_q   = model_q ^ 4'b1111;
    model_cnt = 8'd0;
    check("rstmid_j", jk_j, 4'b0000);
    check("rstmid_k", jk_k, 4'b0000);
    check("rstmid_done", done, 1'b0);
    check("rstmid_count", cmd_count, 8'd0);
    check("rstmid_ready", bus.cmd_ready, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_idle", bus.cmd_ready, 1'b1);
    check("rstmid_q", jk_q_dut, model_q);

    // 256 zero-mask commands wrap the counter back to zero.
    for (int n = 0; n < 256; n++) send(OP_SET, 4'b0000, 1'b0);
    repeat (2) @(negedge clk);
    check("wrap_count", cmd_count, 8'd0);
    check("wrap_q", jk_q_dut, model_q);

`ifdef JK_BANK_CHECK_EN
    send(OP_LOAD, 4'b0011, 1'b1);
    force_zero = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("err_set", err, 1'b1);
    force_zero = 1'b0;
    send(OP_SET, 4'b0100, 1'b0);
    finish_cmd();
    check("err_sticky", err, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    model_cnt = 8'd0;
    check("err_cleared", err, 1'b0);
    rst = 1'b0;
`else
    send(OP_LOAD, 4'b0011, 1'b0);
    finish_cmd();
    check("err_tied", err, 1'b0);
`endif

    wait_idle();
    repeat (3) @(negedge clk);
    check("sb_empty", sb_q.size(), 0);
    check("final_count", cmd_count, model_cnt);
    check("final_q", jk_q_dut, model_q);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
